// File: rtl/node_packet_injector.sv
// Transmit-side packet injector: small FIFO feeding an MSB-first serializer into a node's shift-in port.
// Optional feature: define INJECTOR_PARITY_EN to append one even-parity bit after the payload LSB.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no frame on the wire; pops the FIFO head when non-empty
// ST_SHIFT | CS high, one bit per cycle, bit counter counts down to 0
// ST_GAP   | single CS-low cycle between frames; may pop the next head
module node_packet_injector #(
    parameter int                  IP_WIDTH      = 3,
    parameter logic [IP_WIDTH-1:0] NODE_IP       = '0,
    parameter int                  PAYLOAD_WIDTH = 8,
    parameter int                  DEPTH         = 4
) (
    input  logic                         shiftInCLK,
    input  logic                         resetN,
    input  logic                         txValid,
    output logic                         txReady,
    input  logic [IP_WIDTH-1:0]          txDest,
    input  logic [PAYLOAD_WIDTH-1:0]     txPayload,
    output logic                         shiftOutData,
    output logic                         shiftOutCS,
    output logic                         txBusy,
    output logic [$clog2(DEPTH+1)-1:0]   txCount
);

    localparam int FRAME_BITS = 2*IP_WIDTH + PAYLOAD_WIDTH;
`ifdef INJECTOR_PARITY_EN
    localparam int SER_BITS = FRAME_BITS + 1;
`else
    localparam int SER_BITS = FRAME_BITS;
`endif
    localparam int ENTRY_W = IP_WIDTH + PAYLOAD_WIDTH;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int BIT_W   = $clog2(SER_BITS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [ENTRY_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [1:0]          state_q, state_d;
    logic [SER_BITS-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;
    logic                data_q, data_d;
    logic                cs_q, cs_d;

    logic                  push, pop;
    logic [ENTRY_W-1:0]    head;
    logic [FRAME_BITS-1:0] head_frame;
    logic [SER_BITS-1:0]   head_ser;

    assign head       = mem_q[rd_ptr_q];
    assign head_frame = {head[ENTRY_W-1:PAYLOAD_WIDTH], NODE_IP, head[PAYLOAD_WIDTH-1:0]};
`ifdef INJECTOR_PARITY_EN
    assign head_ser   = {head_frame, ^head_frame};
`else
    assign head_ser   = head_frame;
`endif

    // A full FIFO refuses the push even when the serializer pops on the same edge.
    assign txReady = (count_q < CNT_W'(DEPTH));
    assign push    = txValid && txReady;
    assign pop     = (count_q != '0) && ((state_q == ST_IDLE) || (state_q == ST_GAP));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        data_d   = data_q;
        cs_d     = cs_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE, ST_GAP: begin
                state_d = ST_IDLE;
                cs_d    = 1'b0;
                data_d  = 1'b0;
                if (pop) begin
                    state_d  = ST_SHIFT;
                    shreg_d  = head_ser;
                    bitcnt_d = BIT_W'(SER_BITS-1);
                    data_d   = head_ser[SER_BITS-1];
                    cs_d     = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bitcnt_q == '0) begin
                    state_d = ST_GAP;
                    cs_d    = 1'b0;
                    data_d  = 1'b0;
                end else begin
                    shreg_d  = shreg_q << 1;
                    data_d   = shreg_q[SER_BITS-2];
                    bitcnt_d = bitcnt_q - BIT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_d    = 1'b0;
                data_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge shiftInCLK or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            data_q   <= 1'b0;
            cs_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            data_q   <= data_d;
            cs_q     <= cs_d;
        end
    end

    // Storage is only read behind a non-zero count, so it needs no reset.
    always_ff @(posedge shiftInCLK) begin
        if (push) mem_q[wr_ptr_q] <= {txDest, txPayload};
    end

    assign shiftOutData = data_q;
    assign shiftOutCS   = cs_q;
    assign txBusy       = (state_q != ST_IDLE);
    assign txCount      = count_q;

endmodule
